// File: rtl/key_input_pio_if.sv
// key_input_pio_if -- Avalon-MM slave bus for the key input PIO.
// Groups the word address, select, write strobe, data buses and the level
// interrupt so the PIO and its master connect through a single port.
`timescale 1ns/1ps

interface key_input_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );
endinterface

// File: rtl/key_input_pio.sv
// key_input_pio -- debounced key input PIO with edge capture and interrupt.
// Keys are synchronised, optionally debounced, and active edges latch into
// EDGECAPTURE; irq is the OR of EDGECAPTURE masked by IRQMASK.
// Register map (word addresses): 0 DATA (ro), 1 reserved, 2 IRQMASK (rw),
// 3 EDGECAPTURE (write-1-to-clear).
// Build option: define KEY_INPUT_PIO_DEBOUNCE_EN to include the per-bit
// debounce counters; without it the stable level is the synchroniser output
// registered once.
`timescale 1ns/1ps

module key_input_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_POL        = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   key_input_pio_if.slave   bus,
   input  logic [WIDTH-1:0] in_port
);

   // Level the keys rest at: released active-low keys read high.
   localparam logic [WIDTH-1:0] IDLE = (EDGE_POL != 0) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};

   // Reject configurations the logic below cannot represent.
   if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
      $error("key_input_pio: WIDTH must be 1..32 and DEBOUNCE_CYCLES at least 2");
   end

   logic [WIDTH-1:0] sync_meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] key_edge;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] clear_bits;
   logic [31:0]      rd_next;
   logic             wr_en;

   // Two-flop synchroniser bringing the asynchronous keys into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= IDLE;
         sync      <= IDLE;
      end else begin
         sync_meta <= in_port;
         sync      <= sync_meta;
      end
   end

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] debounce_cnt [WIDTH];

   // Per-bit debounce: a new level is accepted only after it has held for DEBOUNCE_CYCLES clocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= IDLE;
         for (int i = 0; i < WIDTH; i++) begin
            debounce_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
               debounce_cnt[i] <= '0;
            end else if (debounce_cnt[i] == CNT_LAST) begin
               stable[i]       <= sync[i];
               debounce_cnt[i] <= '0;
            end else begin
               debounce_cnt[i] <= debounce_cnt[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   // Without debouncing the accepted level is simply the synchroniser output one clock later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= IDLE;
      end else begin
         stable <= sync;
      end
   end
`endif

   // Delayed copy of the accepted level used to spot edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d <= IDLE;
      end else begin
         stable_d <= stable;
      end
   end

   // Both copies reset to IDLE, so no spurious edge can appear right after reset release.
   assign key_edge = (EDGE_POL != 0) ? (stable & ~stable_d) : (~stable & stable_d);

   assign wr_en      = bus.chipselect && !bus.write_n;
   assign clear_bits = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

   // Mask and edge-capture registers; a new edge beats a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask     <= '0;
         edge_capture <= '0;
      end else begin
         if (wr_en && bus.address == 2'd2) begin
            irq_mask <= bus.writedata[WIDTH-1:0];
         end
         edge_capture <= (edge_capture & ~clear_bits) | key_edge;
      end
   end

   // Zero-extended read mux for the register addressed this cycle.
   always_comb begin
      rd_next = '0;
      case (bus.address)
         2'd0: rd_next[WIDTH-1:0] = stable;
         2'd1: rd_next            = '0;
         2'd2: rd_next[WIDTH-1:0] = irq_mask;
         2'd3: rd_next[WIDTH-1:0] = edge_capture;
      endcase
   end

   // Read data is registered every clock, regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
      end else begin
         bus.readdata <= rd_next;
      end
   end

   assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_key_input_pio.sv
// tb_key_input_pio -- directed test of key_input_pio with WIDTH=4,
// DEBOUNCE_CYCLES=4, EDGE_POL=0. Expectations follow KEY_INPUT_PIO_DEBOUNCE_EN:
// DATA latency is 6 clocks with debouncing and 3 clocks without, and short
// glitches are only filtered when debouncing is built in.
`timescale 1ns/1ps

module tb_key_input_pio;

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
   localparam int  LAT      = 6;
   localparam bit  FILTERED = 1'b1;
`else
   localparam int  LAT      = 3;
   localparam bit  FILTERED = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic [3:0] in_port;
   int         total;
   int         bad;
   logic [31:0] rd;
   logic [31:0] acc;

   key_input_pio_if bus_if ();

   key_input_pio #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .EDGE_POL        (0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if),
      .in_port (in_port)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Drives one bus cycle, clocks it in, then returns the strobes to idle.
   task automatic applyStimulus(input logic [1:0] addr, input logic cs, input logic wr_n, input logic [31:0] wdata);
      bus_if.address    = addr;
      bus_if.chipselect = cs;
      bus_if.write_n    = wr_n;
      bus_if.writedata  = wdata;
      @(posedge clk);
      #1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
   endtask

   // One read: the address is registered on the next edge and visible just after it.
   task automatic readReg(input logic [1:0] addr, input logic cs, output logic [31:0] data);
      applyStimulus(addr, cs, 1'b1, 32'h0);
      data = bus_if.readdata;
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Directed sequence.
   initial begin
      total             = 0;
      bad               = 0;
      reset_n           = 1'b0;
      in_port           = 4'hF;
      bus_if.address    = 2'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = 32'h0;
      $display("[TB] starting, DATA latency %0d clocks", LAT);

      waitClocks(3);
      reset_n = 1'b1;
      waitClocks(3);

      // Reset state.
      readReg(2'd0, 1'b1, rd); checkOutput("reset_data", rd, 32'h0000000F);
      readReg(2'd2, 1'b1, rd); checkOutput("reset_mask", rd, 32'h00000000);
      readReg(2'd3, 1'b1, rd); checkOutput("reset_edge", rd, 32'h00000000);
      checkOutput("reset_irq", {31'b0, bus_if.irq}, 32'h0);

      // Bit0 falls and holds: DATA changes exactly LAT clocks later.
      bus_if.address = 2'd0;
      in_port = 4'hE;
      waitClocks(LAT);
      checkOutput("lat_before", bus_if.readdata, 32'h0000000F);
      waitClocks(1);
      checkOutput("lat_after", bus_if.readdata, 32'h0000000E);
      readReg(2'd3, 1'b1, rd); checkOutput("edge_bit0", rd, 32'h00000001);
      checkOutput("irq_unmasked", {31'b0, bus_if.irq}, 32'h0);

      // Releasing the key is a rising edge and is not captured.
      in_port = 4'hF;
      waitClocks(LAT + 3);
      readReg(2'd0, 1'b1, rd); checkOutput("release_data", rd, 32'h0000000F);
      readReg(2'd3, 1'b1, rd); checkOutput("release_edge", rd, 32'h00000001);

      // Bit1 glitches low for 3 clocks.
      in_port = 4'hD;
      waitClocks(3);
      in_port = 4'hF;
      acc = 32'hFFFFFFFF;
      for (int i = 0; i < 10; i++) begin
         readReg(2'd0, 1'b0, rd);
         acc = acc & rd;
      end
      checkOutput("glitch_data", acc, FILTERED ? 32'h0000000F : 32'h0000000D);
      readReg(2'd3, 1'b1, rd); checkOutput("glitch_edge", rd, FILTERED ? 32'h00000001 : 32'h00000003);

      // Mask write ignores upper data bits and raises irq.
      applyStimulus(2'd2, 1'b1, 1'b0, 32'hFFFFFFF1);
      checkOutput("irq_set", {31'b0, bus_if.irq}, 32'h1);
      readReg(2'd2, 1'b1, rd); checkOutput("mask_read", rd, 32'h00000001);

      // Writes without chipselect and to the reserved word do nothing.
      applyStimulus(2'd2, 1'b0, 1'b0, 32'h0000000F);
      readReg(2'd2, 1'b1, rd); checkOutput("mask_no_cs", rd, 32'h00000001);
      applyStimulus(2'd1, 1'b1, 1'b0, 32'hFFFFFFFF);
      readReg(2'd1, 1'b1, rd); checkOutput("reserved", rd, 32'h00000000);

      // Write-1-to-clear of bit0 drops irq immediately after the edge.
      applyStimulus(2'd3, 1'b1, 1'b0, 32'h00000001);
      checkOutput("irq_clear", {31'b0, bus_if.irq}, 32'h0);
      readReg(2'd3, 1'b1, rd); checkOutput("edge_cleared", rd, FILTERED ? 32'h00000000 : 32'h00000002);

      // A clear landing on the same clock as a new bit0 edge loses to the set.
      in_port = 4'hE;
      waitClocks(LAT);
      applyStimulus(2'd3, 1'b1, 1'b0, 32'h00000001);
      checkOutput("collide_irq", {31'b0, bus_if.irq}, 32'h1);
      readReg(2'd3, 1'b1, rd); checkOutput("collide_edge", rd, FILTERED ? 32'h00000001 : 32'h00000003);

      // Clear everything, then bit3 falls while bit0 rises.
      applyStimulus(2'd3, 1'b1, 1'b0, 32'h0000000F);
      checkOutput("clear_all_irq", {31'b0, bus_if.irq}, 32'h0);
      bus_if.address = 2'd0;
      in_port = 4'h7;
      waitClocks(LAT);
      checkOutput("bit3_before", bus_if.readdata, 32'h0000000E);
      waitClocks(1);
      checkOutput("bit3_after", bus_if.readdata, 32'h00000007);
      readReg(2'd3, 1'b1, rd); checkOutput("bit3_edge", rd, 32'h00000008);
      checkOutput("bit3_irq", {31'b0, bus_if.irq}, 32'h0);

      // Reset asserted mid-debounce clears everything asynchronously.
      in_port = 4'h0;
      waitClocks(2);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_async_rd", bus_if.readdata, 32'h0);
      checkOutput("rst_async_irq", {31'b0, bus_if.irq}, 32'h0);
      in_port = 4'hF;
      waitClocks(2);
      reset_n = 1'b1;
      readReg(2'd3, 1'b1, rd); checkOutput("rst_first_edge", rd, 32'h00000000);
      waitClocks(LAT + 2);
      readReg(2'd0, 1'b1, rd); checkOutput("rst_data", rd, 32'h0000000F);
      readReg(2'd3, 1'b1, rd); checkOutput("rst_edge", rd, 32'h00000000);
      readReg(2'd2, 1'b1, rd); checkOutput("rst_mask", rd, 32'h00000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/key_input_pio.md
KEY_INPUT_PIO -- requirements
Module: key_input_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of input bits (legal range 1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive clocks a synchronised bit must hold a new level before it is accepted (legal minimum 2).
REQ-003 The block SHALL have parameter EDGE_POL, default 0: 0 = capture falling edges (active-low keys), 1 = capture rising edges.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-007 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 The block SHALL have port writedata, input, 32 bits: write data.
REQ-010 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 The block SHALL have port in_port, input, WIDTH bits: asynchronous key inputs.
REQ-012 The block SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 in_port SHALL pass through a two-flop synchroniser per bit; the output of the second flop is called "sync".
REQ-014 Each bit SHALL have a debounce counter: while sync equals stable, the counter is held at 0; while they differ, it increments each clock.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and sync still differs, stable SHALL take sync on that edge and the counter SHALL return to 0.
REQ-016 A sync glitch shorter than DEBOUNCE_CYCLES clocks SHALL leave stable unchanged.
REQ-017 An active edge SHALL be stable going 1->0 when EDGE_POL=0, or 0->1 when EDGE_POL=1, detected against a one-cycle-delayed copy of stable.
REQ-018 Register map, word addresses: 0 = DATA (stable, read-only); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (WIDTH bits, read/write); 3 = EDGECAPTURE (WIDTH bits, write-1-to-clear).
REQ-019 An active edge on bit i SHALL set EDGECAPTURE[i], which then holds until cleared.
REQ-020 A write to address 3 SHALL clear every EDGECAPTURE bit whose writedata bit is 1; if a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-021 Writes SHALL take effect on the clock edge where chipselect=1 and write_n=0; writedata bits [31:WIDTH] SHALL be ignored.
REQ-022 readdata SHALL be registered every clock from the address-selected register, zero-extended, giving a one-cycle read latency independent of chipselect.
REQ-023 irq SHALL equal the OR of (EDGECAPTURE AND IRQMASK), driven combinationally from registers.
REQ-024 Total latency from an in_port change to a DATA change SHALL be 2 + DEBOUNCE_CYCLES clocks, with readdata reflecting it 1 clock later.

Reset
REQ-025 On reset_n low, the block SHALL asynchronously set the synchroniser flops, stable, and the delayed-stable copy to the idle level: all ones when EDGE_POL=0, all zeros when EDGE_POL=1.
REQ-026 On reset_n low, the block SHALL clear the counters, IRQMASK, EDGECAPTURE, readdata and irq to 0.
REQ-027 A reset asserted mid-debounce SHALL abort the count, and no edge SHALL be captured on the first clock after reset release.

Configuration
REQ-028 With macro KEY_INPUT_PIO_DEBOUNCE_EN defined, the counters and REQ-014..016 SHALL be implemented.
REQ-029 With KEY_INPUT_PIO_DEBOUNCE_EN undefined, there SHALL be no counters, stable SHALL equal sync registered once, and the DATA latency SHALL be 3 clocks; the register map and irq behaviour SHALL be unchanged.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_POL=0, macro defined unless stated)
REQ-030 Reset, then read addresses 0, 2, 3 -> readdata 0x0000000F, 0x00000000, 0x00000000; irq=0.
REQ-031 in_port 0xF->0xE held -> DATA reads 0xE exactly 6 clocks after the change; EDGECAPTURE=0x1.
REQ-032 in_port bit1 pulsed low for 3 clocks -> DATA stays 0xF; EDGECAPTURE unchanged.
REQ-033 Write IRQMASK=0x1 with EDGECAPTURE=0x1 -> irq=1; write 0x1 to address 3 -> irq=0 the next cycle; a clear coinciding with a new bit0 edge -> bit stays 1.
REQ-034 Macro undefined: in_port 0xF->0x7 -> DATA=0x7 after 3 clocks; EDGECAPTURE=0x8.
